// File: rtl/bramdp_ctl.sv
// ---------------------------------------------------------------------------
// bramdp_ctl
// This is a true dual-port RAM on a single clock. It stores waveform and LUT
// data. It has:
//   - lane write enables,
//   - a read latency of 1 or 2 cycles,
//   - a selectable read-during-write result,
//   - cross-port collision flagging,
//   - a fill engine that sweeps the whole array to FILL_VAL.
//
// Ports:
//   clk, rstn              single clock; asynchronous active-low reset
//   clr_start              pulse that starts a fill when the engine is idle
//   clr_busy / clr_done    fill in progress / one-cycle completion pulse
//   a_* / b_*              two identical access ports:
//                            req/ready handshake (requests dropped when not ready)
//                            we  = lane write enables (all zero = read)
//                            addr, din
//                            dout and dvalid, RD_LAT cycles after acceptance
//   collision              pulse: both ports hit one address and at least one wrote
// ---------------------------------------------------------------------------
module bramdp_ctl #(
  parameter int              ABITS    = 12,
  parameter int              DBITS    = 8,
  parameter int              LANES    = 1,
  parameter int              RD_LAT   = 1,
  parameter int              RDW_MODE = 0,
  parameter logic [DBITS-1:0] FILL_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_done,
  input  logic             a_req,
  output logic             a_ready,
  input  logic [LANES-1:0] a_we,
  input  logic [ABITS-1:0] a_addr,
  input  logic [DBITS-1:0] a_din,
  output logic [DBITS-1:0] a_dout,
  output logic             a_dvalid,
  input  logic             b_req,
  output logic             b_ready,
  input  logic [LANES-1:0] b_we,
  input  logic [ABITS-1:0] b_addr,
  input  logic [DBITS-1:0] b_din,
  output logic [DBITS-1:0] b_dout,
  output logic             b_dvalid,
  output logic             collision
);

  localparam int DEPTH = 1 << ABITS;
  localparam int LW    = DBITS / LANES;
  localparam logic [ABITS:0] CNT_LAST = (ABITS + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} fill_state_e;

  fill_state_e      state_q;
  logic [ABITS:0]   cnt_q;
  logic [DBITS-1:0] mem [DEPTH];

  logic             a_acc, b_acc;
  logic [DBITS-1:0] a_merged, b_merged, a_rdata, b_rdata;
  logic             a_v1_q, b_v1_q, coll_q;
  logic [DBITS-1:0] a_d1_q, b_d1_q;

  // Fill engine. The counter has one spare bit. Termination is detected at
  // DEPTH-1, so the counter never wraps back onto live addresses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (clr_start) begin
          state_q <= ST_FILL;
          cnt_q   <= '0;
        end
        ST_FILL: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign clr_busy = (state_q == ST_FILL);
  assign clr_done = (state_q == ST_DONE);
  assign a_ready  = !clr_busy;
  assign b_ready  = !clr_busy;
  assign a_acc    = a_req && a_ready;
  assign b_acc    = b_req && b_ready;

  // NOTE: the array has no reset branch. Clearing every word would turn the
  // RAM into flops. Contents are instead cleared on demand by the fill engine.
  // Port A's lane writes come after port B's in this block. When both ports
  // enable the same lane of the same word, A's value is the one that lands.
  always_ff @(posedge clk) begin
    if (state_q == ST_FILL) mem[cnt_q[ABITS-1:0]] <= FILL_VAL;
    for (int l = 0; l < LANES; l++) begin
      if (b_acc && b_we[l]) mem[b_addr][l*LW +: LW] <= b_din[l*LW +: LW];
      if (a_acc && a_we[l]) mem[a_addr][l*LW +: LW] <= a_din[l*LW +: LW];
    end
  end

  // Merged word: the port's own written lanes over the stored word. It is
  // returned on that port when RDW_MODE selects new data.
  always_comb begin
    // NOTE: defaults are assigned first so that no path leaves these
    // unassigned, which would infer a latch.
    a_merged = mem[a_addr];
    b_merged = mem[b_addr];
    for (int l = 0; l < LANES; l++) begin
      if (a_we[l]) a_merged[l*LW +: LW] = a_din[l*LW +: LW];
      if (b_we[l]) b_merged[l*LW +: LW] = b_din[l*LW +: LW];
    end
  end

  assign a_rdata = (RDW_MODE != 0) ? a_merged : mem[a_addr];
  assign b_rdata = (RDW_MODE != 0) ? b_merged : mem[b_addr];

  // First read stage. The data registers load only on acceptance, so the
  // outputs hold their values between dvalid pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      a_d1_q <= '0;
      b_d1_q <= '0;
      coll_q <= 1'b0;
    end else begin
      a_v1_q <= a_acc;
      b_v1_q <= b_acc;
      if (a_acc) a_d1_q <= a_rdata;
      if (b_acc) b_d1_q <= b_rdata;
      coll_q <= a_acc && b_acc && (a_addr == b_addr) && ((|a_we) || (|b_we));
    end
  end

  assign collision = coll_q;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             a_v2_q, b_v2_q;
      logic [DBITS-1:0] a_d2_q, b_d2_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_v2_q <= 1'b0;
          b_v2_q <= 1'b0;
          a_d2_q <= '0;
          b_d2_q <= '0;
        end else begin
          a_v2_q <= a_v1_q;
          b_v2_q <= b_v1_q;
          if (a_v1_q) a_d2_q <= a_d1_q;
          if (b_v1_q) b_d2_q <= b_d1_q;
        end
      end

      assign a_dout   = a_d2_q;
      assign a_dvalid = a_v2_q;
      assign b_dout   = b_d2_q;
      assign b_dvalid = b_v2_q;
    end else begin : g_lat1
      assign a_dout   = a_d1_q;
      assign a_dvalid = a_v1_q;
      assign b_dout   = b_d1_q;
      assign b_dvalid = b_v1_q;
    end
  endgenerate

endmodule
